seven_seg_scan_ctrl: RTL and testbench

- Scan scheduler for a time-multiplexed, common-segment 7-segment display of DIGITS digits.
- Owns a double-buffered digit register file that a host writes through a valid/ready port.
- Cycles a one-hot digit enable through all digits, with a blanking gap between digits to prevent ghosting.
- Commits new host data only at frame boundaries, so the display never shows a half-updated frame.

---
 rtl/seven_seg_scan_ctrl.sv | 154 +++++++++++++++
 tb/tb_seven_seg_scan_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller with a double-buffered digit file.
// Host writes land in pending[]; active[] is refreshed only at frame boundaries or while idle.
module seven_seg_scan_ctrl #(
  parameter int DIGITS = 4,
  parameter int DWELL  = 40000,
  parameter int BLANK  = 16,
  parameter int CBITS  = 16,
  parameter int ABITS  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ABITS-1:0]  wr_addr,
  input  logic [6:0]        wr_data,
  output logic [6:0]        segment,
  output logic [DIGITS-1:0] digit_en,
  output logic              frame_done
);

  typedef enum logic [1:0] {S_IDLE, S_BLANK, S_SHOW} state_t;

  localparam logic [CBITS-1:0] BLANK_LAST = CBITS'(BLANK - 1);
  localparam logic [CBITS-1:0] DWELL_LAST = CBITS'(DWELL - 1);
  localparam logic [ABITS-1:0] IDX_LAST   = ABITS'(DIGITS - 1);

  state_t              state_q, state_d;
  logic [CBITS-1:0]    cnt_q, cnt_d;
  logic [ABITS-1:0]    idx_q, idx_d;
  logic [6:0]          pending_q [DIGITS];
  logic [6:0]          pending_d [DIGITS];
  logic [6:0]          active_q  [DIGITS];
  logic [6:0]          active_d  [DIGITS];
  logic [6:0]          seg_q, seg_d;
  logic [DIGITS-1:0]   den_q, den_d;
  logic                fd_q, fd_d;
  logic                frame_end;
  logic                wr_keep;
  logic                commit;

  assign frame_end  = (state_q == S_SHOW) && (cnt_q == DWELL_LAST) && (idx_q == IDX_LAST);
  assign wr_ready   = !frame_end;
  assign wr_keep    = wr_valid && wr_ready && (32'(wr_addr) < DIGITS);

  assign segment    = seg_q;
  assign digit_en   = den_q;
  assign frame_done = fd_q;

  always_comb begin
    for (int unsigned i = 0; i < DIGITS; i++) pending_d[i] = pending_q[i];
    if (wr_keep) pending_d[wr_addr] = wr_data;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    seg_d   = seg_q;
    den_d   = den_q;
    fd_d    = 1'b0;
    commit  = 1'b0;
    case (state_q)
      S_IDLE: begin
        commit = 1'b1;
        seg_d  = '0;
        den_d  = '0;
        if (enable) begin
          state_d = S_BLANK;
          cnt_d   = '0;
          idx_d   = '0;
        end
      end
      S_BLANK: begin
        if (!enable) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          idx_d   = '0;
          seg_d   = '0;
          den_d   = '0;
        end else if (cnt_q == BLANK_LAST) begin
          state_d       = S_SHOW;
          cnt_d         = '0;
          seg_d         = active_q[idx_q];
          den_d         = '0;
          den_d[idx_q]  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_SHOW: begin
        if (!enable) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          idx_d   = '0;
          seg_d   = '0;
          den_d   = '0;
        end else if (cnt_q == DWELL_LAST) begin
          state_d = S_BLANK;
          cnt_d   = '0;
          seg_d   = '0;
          den_d   = '0;
          if (idx_q == IDX_LAST) begin
            idx_d  = '0;
            commit = 1'b1;
            fd_d   = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        idx_d   = '0;
        seg_d   = '0;
        den_d   = '0;
      end
    endcase
  end

  always_comb begin
    for (int unsigned i = 0; i < DIGITS; i++) active_d[i] = commit ? pending_d[i] : active_q[i];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      seg_q   <= '0;
      den_q   <= '0;
      fd_q    <= 1'b0;
      for (int unsigned i = 0; i < DIGITS; i++) begin
        pending_q[i] <= '0;
        active_q[i]  <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      seg_q   <= seg_d;
      den_q   <= den_d;
      fd_q    <= fd_d;
      for (int unsigned i = 0; i < DIGITS; i++) begin
        pending_q[i] <= pending_d[i];
        active_q[i]  <= active_d[i];
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scan_ctrl.sv
// Bench for seven_seg_scan_ctrl: frame-position reference model plus a 3-digit instance.
module tb_seven_seg_scan_ctrl;

  localparam int DIG  = 4;
  localparam int DW   = 5;
  localparam int BL   = 2;
  localparam int SLOT = BL + DW;
  localparam int F    = DIG * SLOT;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0, v = 1'b0;
  logic [1:0] a = '0;
  logic [6:0] d = '0;
  logic       rdy, fd;
  logic [6:0] seg;
  logic [3:0] den;

  logic       en3 = 1'b0, v3 = 1'b0;
  logic [1:0] a3 = '0;
  logic [6:0] d3 = '0;
  logic       rdy3, fd3;
  logic [6:0] seg3;
  logic [2:0] den3;

  always #5 clk = ~clk;

  seven_seg_scan_ctrl #(.DIGITS(DIG), .DWELL(DW), .BLANK(BL), .CBITS(4), .ABITS(2)) u_dut (
    .clk(clk), .rst(rst), .enable(en), .wr_valid(v), .wr_ready(rdy), .wr_addr(a),
    .wr_data(d), .segment(seg), .digit_en(den), .frame_done(fd)
  );

  seven_seg_scan_ctrl #(.DIGITS(3), .DWELL(DW), .BLANK(BL), .CBITS(4), .ABITS(2)) u_dut3 (
    .clk(clk), .rst(rst), .enable(en3), .wr_valid(v3), .wr_ready(rdy3), .wr_addr(a3),
    .wr_data(d3), .segment(seg3), .digit_en(den3), .frame_done(fd3)
  );

  // Reference model: position within the frame decides everything displayed.
  bit         run = 1'b0;
  int         pos = 0;
  bit         fd_m = 1'b0;
  logic [6:0] pend [DIG];
  logic [6:0] act  [DIG];
  int         checks = 0;
  int         errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    run = 1'b0; pos = 0; fd_m = 1'b0;
    for (int i = 0; i < DIG; i++) begin pend[i] = '0; act[i] = '0; end
  endtask

  task automatic check_outputs();
    logic [6:0] se;
    logic [3:0] de;
    se = '0; de = '0;
    if (run && (pos % SLOT) >= BL) begin
      de = 4'b0001 << (pos / SLOT);
      se = act[pos / SLOT];
    end
    chk("segment", 32'(seg), 32'(se));
    chk("digit_en", 32'(den), 32'(de));
    chk("frame_done", 32'(fd), 32'(fd_m));
    chk("onehot0", 32'($onehot0(den)), 32'd1);
  endtask

  task automatic step(input bit e, input bit vv, input logic [1:0] aa, input logic [6:0] dd);
    bit rdy_e, fire, wrap;
    en = e; v = vv; a = aa; d = dd;
    #1;
    rdy_e = !(run && pos == F - 1);
    chk("wr_ready", 32'(rdy), 32'(rdy_e));
    fire = vv && rdy_e;
    @(posedge clk);
    if (!run) begin
      if (fire) pend[aa] = dd;
      for (int i = 0; i < DIG; i++) act[i] = pend[i];
      fd_m = 1'b0;
      if (e) begin run = 1'b1; pos = 0; end
    end else if (!e) begin
      if (fire) pend[aa] = dd;
      run = 1'b0; pos = 0; fd_m = 1'b0;
    end else begin
      wrap = (pos == F - 1);
      if (fire) pend[aa] = dd;
      if (wrap) begin
        for (int i = 0; i < DIG; i++) act[i] = pend[i];
        pos = 0;
      end else begin
        pos++;
      end
      fd_m = wrap;
    end
    #1;
    check_outputs();
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] pat [4];
    logic [6:0] p3 [3];
    int lit3 [3];
    int guard;
    pat[0] = 7'h3F; pat[1] = 7'h06; pat[2] = 7'h5B; pat[3] = 7'h4F;
    p3[0] = 7'h11; p3[1] = 7'h22; p3[2] = 7'h33;
    model_clear();

    #2 rst = 1'b0;
    #2;
    check_outputs();
    chk("reset_ready", 32'(rdy), 32'd1);
    @(posedge clk);
    #1 rst = 1'b1;

    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 2'(i), pat[i]);

    // Two frames; addr 2 rewritten during digit 0 SHOW.
    step(1'b1, 1'b0, 2'd0, 7'h00);
    for (int k = 0; k < 2 * F; k++) begin
      if (k == 3) step(1'b1, 1'b1, 2'd2, 7'h7F);
      else        step(1'b1, 1'b0, 2'd0, 7'h00);
    end

    // Continuous write traffic.
    for (int k = 0; k < 2 * F; k++)
      step(1'b1, 1'b1, 2'($urandom_range(0, 3)), 7'($urandom));

    // Drop enable at cnt==2 of digit 1 SHOW.
    guard = 0;
    while (!(run && pos == SLOT + BL + 2) && guard < 2 * F) begin
      step(1'b1, 1'b0, 2'd0, 7'h00);
      guard++;
    end
    chk("reach_drop_point", 32'(guard < 2 * F), 32'd1);
    step(1'b0, 1'b0, 2'd0, 7'h00);
    step(1'b0, 1'b0, 2'd0, 7'h00);
    for (int k = 0; k < F + 3; k++) step(1'b1, 1'b0, 2'd0, 7'h00);

    // Asynchronous reset in the middle of a SHOW phase.
    guard = 0;
    while (!(run && (pos % SLOT) == BL + 2) && guard < 2 * F) begin
      step(1'b1, 1'b0, 2'd0, 7'h00);
      guard++;
    end
    chk("reach_show", 32'(den != 4'd0), 32'd1);
    #2 rst = 1'b0;
    #1;
    model_clear();
    check_outputs();
    chk("async_rst_ready", 32'(rdy), 32'd1);
    #2 rst = 1'b1;
    for (int k = 0; k < F + 2; k++) step(1'b1, 1'b0, 2'd0, 7'h00);

    // Randomised run with occasional disable.
    for (int k = 0; k < 400; k++)
      step(($urandom_range(0, 19) != 0), 1'($urandom), 2'($urandom_range(0, 3)), 7'($urandom));
    step(1'b0, 1'b0, 2'd0, 7'h00);
    en = 1'b0;

    // Three-digit instance: out-of-range address is accepted and dropped.
    for (int i = 0; i < 4; i++) begin
      v3 = 1'b1; a3 = 2'(i); d3 = (i < 3) ? p3[i] : 7'h7F;
      #1 chk("d3_ready", 32'(rdy3), 32'd1);
      @(posedge clk); #1;
    end
    v3 = 1'b0;
    en3 = 1'b1;
    for (int i = 0; i < 3; i++) lit3[i] = 0;
    for (int k = 0; k < 44; k++) begin
      @(posedge clk); #1;
      chk("d3_onehot0", 32'($onehot0(den3)), 32'd1);
      for (int i = 0; i < 3; i++)
        if (den3[i]) begin
          lit3[i]++;
          chk("d3_segment", 32'(seg3), 32'(p3[i]));
        end
      if (den3 == 3'd0) chk("d3_dark_seg", 32'(seg3), 32'd0);
    end
    for (int i = 0; i < 3; i++) chk("d3_lit_cycles", 32'(lit3[i]), 32'd10);
    en3 = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
